// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the Beta decode/hazard stage.
//   - opcode constants for the instruction classes the stage cares about
//   - dec_ctl_t : packed class flags {ld, st, ldr, jmp, beq, bne, op, opc}
//   - dec_state_e : decode FSM states
//   - INST_NOP : ADD(R31,R31,R31), emitted in place of squashed instructions
//   - decode_ctl() : instruction word -> class flags
package decode_pkg;

   localparam logic [5:0]  OPC_LD   = 6'h18;
   localparam logic [5:0]  OPC_ST   = 6'h19;
   localparam logic [5:0]  OPC_JMP  = 6'h1B;
   localparam logic [5:0]  OPC_BEQ  = 6'h1C;
   localparam logic [5:0]  OPC_BNE  = 6'h1D;
   localparam logic [5:0]  OPC_LDR  = 6'h1F;
   localparam logic [4:0]  REG_ZERO = 5'd31;
   localparam logic [31:0] INST_NOP = 32'h83FF_F800;

   typedef struct packed {
      logic ld;
      logic st;
      logic ldr;
      logic jmp;
      logic beq;
      logic bne;
      logic op;   // register-register ALU, opcodes 0x20-0x2F
      logic opc;  // register-literal ALU, opcodes 0x30-0x3F
   } dec_ctl_t;

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_FULL   = 2'd1,
      S_STALL  = 2'd2,
      S_SHADOW = 2'd3
   } dec_state_e;

   function automatic dec_ctl_t decode_ctl(input logic [31:0] ir);
      dec_ctl_t c;
      c = '0;
      case (ir[31:26])
         OPC_LD:  c.ld  = 1'b1;
         OPC_ST:  c.st  = 1'b1;
         OPC_LDR: c.ldr = 1'b1;
         OPC_JMP: c.jmp = 1'b1;
         OPC_BEQ: c.beq = 1'b1;
         OPC_BNE: c.bne = 1'b1;
         default: c = '0;
      endcase
      c.op  = (ir[31:30] == 2'b10);
      c.opc = (ir[31:30] == 2'b11);
      return c;
   endfunction

endpackage

// File: rtl/decode_hazard.sv
// decode_hazard: resolves one source register against the bypass network.
//   src                 : source register number
//   rf_data             : register-file read data for src
//   byp_valid/is_load   : per-channel write present / result not yet available
//   byp_addr/byp_data   : per-channel destination and result (channel 0 youngest)
//   data                : resolved operand value
//   hazard              : youngest matching channel has no data yet (load-use)
// R31 always reads as zero and never hazards.
module decode_hazard
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_BYP = 3
) (
   input  logic [4:0]              src,
   input  logic [XLEN-1:0]         rf_data,
   input  logic [NUM_BYP-1:0]      byp_valid,
   input  logic [NUM_BYP-1:0]      byp_is_load,
   input  logic [5*NUM_BYP-1:0]    byp_addr,
   input  logic [XLEN*NUM_BYP-1:0] byp_data,
   output logic [XLEN-1:0]         data,
   output logic                    hazard
);

   logic found;

   // Only the youngest (lowest-index) match counts; older writes are stale.
   always_comb begin
      data   = rf_data;
      hazard = 1'b0;
      found  = 1'b0;
      if (src == REG_ZERO) begin
         data = '0;
      end else begin
         for (int i = 0; i < NUM_BYP; i++) begin
            if (!found && byp_valid[i] && (byp_addr[5*i +: 5] == src)) begin
               found = 1'b1;
               if (byp_is_load[i]) hazard = 1'b1;
               else                data   = byp_data[XLEN*i +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/decode_hz.sv
// decode_hz: Beta decode stage with operand bypass, load-use stall and
// branch/jump redirect.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : upstream handshake; in_pc is PC+4, in_ir the word
//   out_valid/out_ready       : downstream handshake for the decoded packet
//   out_pc/out_ir/out_a/b/d   : decoded packet; out_ctl class flags
//   rf_ra1/rf_ra2, rf_rd1/2   : register-file read port (combinational data)
//   byp_*                     : bypass channels, channel 0 youngest
//   flush                     : exception flush, highest priority
//   redirect_valid/pc         : taken branch / jump target to fetch
//   stall_cnt                 : cycles spent in STALL (only with DECODE_STALL_CNT_EN)
//   dbg_state                 : current FSM state
// Handshake: a beat moves when valid && ready are both high on a rising edge;
// valid never depends on ready, in_ready may depend on out_ready.
// Optional feature macro: DECODE_STALL_CNT_EN.
module decode_hz
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_BYP = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [31:0]             in_ir,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [31:0]             out_ir,
   output logic [XLEN-1:0]         out_a,
   output logic [XLEN-1:0]         out_b,
   output logic [XLEN-1:0]         out_d,
   output dec_ctl_t                out_ctl,
   output logic [4:0]              rf_ra1,
   output logic [4:0]              rf_ra2,
   input  logic [XLEN-1:0]         rf_rd1,
   input  logic [XLEN-1:0]         rf_rd2,
   input  logic [NUM_BYP-1:0]      byp_valid,
   input  logic [NUM_BYP-1:0]      byp_is_load,
   input  logic [5*NUM_BYP-1:0]    byp_addr,
   input  logic [XLEN*NUM_BYP-1:0] byp_data,
   input  logic                    flush,
   output logic                    redirect_valid,
   output logic [XLEN-1:0]         redirect_pc,
`ifdef DECODE_STALL_CNT_EN
   output logic [31:0]             stall_cnt,
`endif
   output dec_state_e              dbg_state
);

   dec_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     ir_q;
   logic            kill_q;   // register holds a squashed wrong-path slot

   logic            valid, transfer, accept, load_kill, take, hazard;
   logic            haz1, haz2, use1, use2;
   dec_ctl_t        ctl;
   logic [4:0]      src1, src2;
   logic [XLEN-1:0] op_a, op_b, sxt, br_tgt;

   assign valid = (state_q == S_FULL) || (state_q == S_STALL);

   // Decode of the held instruction; squashed or empty slots decode to nothing.
   assign ctl  = (valid && !kill_q) ? decode_ctl(ir_q) : '0;
   assign src1 = ir_q[20:16];
   assign src2 = ctl.st ? ir_q[25:21] : ir_q[15:11];

   assign rf_ra1 = valid ? src1 : 5'd0;
   assign rf_ra2 = valid ? src2 : 5'd0;

   decode_hazard #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_haz_a (
      .src(src1), .rf_data(rf_rd1), .byp_valid(byp_valid), .byp_is_load(byp_is_load),
      .byp_addr(byp_addr), .byp_data(byp_data), .data(op_a), .hazard(haz1)
   );

   decode_hazard #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_haz_b (
      .src(src2), .rf_data(rf_rd2), .byp_valid(byp_valid), .byp_is_load(byp_is_load),
      .byp_addr(byp_addr), .byp_data(byp_data), .data(op_b), .hazard(haz2)
   );

   // A source only stalls the stage if the instruction actually reads it.
   assign use1   = ctl.ld | ctl.st | ctl.jmp | ctl.beq | ctl.bne | ctl.op | ctl.opc;
   assign use2   = ctl.st | ctl.op;
   assign hazard = (haz1 & use1) | (haz2 & use2);

   assign sxt    = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
   assign br_tgt = pc_q + (sxt << 2);

   assign out_valid = (state_q == S_FULL) && !hazard;
   assign transfer  = out_valid && out_ready;
   assign in_ready  = !rst && !flush && (state_q != S_STALL) && (!valid || transfer);
   assign accept    = in_valid && in_ready;

   assign take           = ctl.jmp | (ctl.beq && (op_a == '0)) | (ctl.bne && (op_a != '0));
   assign redirect_valid = transfer && take && !flush;
   assign redirect_pc    = !redirect_valid ? '0 :
                           ctl.jmp ? {op_a[XLEN-1:2], 2'b00} : br_tgt;

   // An instruction accepted on the redirect cycle, or while in SHADOW, is
   // from the wrong path and is replaced by a NOP.
   assign load_kill = (state_q == S_SHADOW) || redirect_valid;

   assign out_pc  = valid ? pc_q : '0;
   assign out_ir  = valid ? ir_q : INST_NOP;
   assign out_ctl = ctl;
   assign out_a   = !valid ? '0 : (ctl.ldr ? br_tgt : op_a);
   assign out_b   = !valid ? '0 : ((ctl.ld | ctl.st | ctl.opc) ? sxt : op_b);
   assign out_d   = valid ? op_b : '0;   // second read port: Rc for stores
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY, S_SHADOW: if (accept) state_d = S_FULL;
            S_FULL: begin
               if (transfer) begin
                  if (!accept) state_d = redirect_valid ? S_SHADOW : S_EMPTY;
               end else if (hazard) begin
                  state_d = S_STALL;
               end
            end
            S_STALL: if (!hazard) state_d = S_FULL;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         ir_q   <= INST_NOP;
         kill_q <= 1'b0;
      end else if (accept) begin
         pc_q   <= in_pc;
         ir_q   <= load_kill ? INST_NOP : in_ir;
         kill_q <= load_kill;
      end
   end

`ifdef DECODE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                            stall_cnt_q <= '0;
      else if (flush)                                     stall_cnt_q <= '0;
      else if (state_q == S_STALL && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/decode_hz.md
DECODE_HZ -- requirements
Module: decode_hz

Interface
REQ-001 XLEN, 32, datapath width; legal values >= 32.
REQ-002 NUM_BYP, 3, bypass channel count; legal range 1..4; channel 0 is youngest.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 in_valid/in_ready  in/out  1/1  upstream handshake.
REQ-006 in_pc/in_ir  in  XLEN/32  fetched PC+4 and instruction word.
REQ-007 out_valid/out_ready  out/in  1/1  downstream handshake.
REQ-008 out_pc/out_ir/out_a/out_b/out_d  out  XLEN/32/XLEN/XLEN/XLEN  decoded packet.
REQ-009 out_ctl  out  dec_ctl_t  packed class flags: ld, st, ldr, jmp, beq, bne, op, opc.
REQ-010 rf_ra1/rf_ra2  out  5/5; rf_rd1/rf_rd2  in  XLEN/XLEN  regfile read port, combinational data.
REQ-011 byp_valid/byp_is_load  in  NUM_BYP each  channel carries a write / data not yet available.
REQ-012 byp_addr/byp_data  in  5*NUM_BYP / XLEN*NUM_BYP  destination register and result per channel.
REQ-013 flush  in  1  exception flush.
REQ-014 redirect_valid/redirect_pc  out  1/XLEN  taken-branch or jump redirect to fetch.

Function
REQ-015 Beta encoding: Ra=ir[20:16], Rb=ir[15:11], Rc=ir[25:21], C=ir[15:0].
REQ-016 Single decode register (pc, ir, valid) loads when in_valid && in_ready; in_ready = !valid || (out_valid && out_ready).
REQ-017 rf_ra1=Ra; rf_ra2=Rc for ST, else Rb.
REQ-018 Operand resolve per source: R31 -> 0; else lowest-index matching valid channel with !is_load -> byp_data; else rf data.
REQ-019 Load-use: a source matching, at the lowest matching index, a channel with byp_is_load=1 is a hazard; R31 never hazards.
REQ-020 FSM states EMPTY, FULL, STALL, SHADOW.
REQ-021 EMPTY->FULL on accept; FULL->STALL while hazard; STALL->FULL when hazard clears; FULL->EMPTY on transfer with no accept.
REQ-022 In STALL: out_valid=0, in_ready=0, decode register held.
REQ-023 out_a = LDR ? pc+SXT(C)*4 : operand A; out_b = (LD|ST|opc) ? SXT(C) : operand B; out_d = operand Rc.
REQ-024 redirect_valid pulses on transfer cycle of JMP (target = operand A with low 2 bits cleared), BEQ with A==0, BNE with A!=0 (target = pc+SXT(C)*4).
REQ-025 After a redirect, FSM enters SHADOW; the next accepted instruction is replaced by NOP (ir=`INST_NOP, ctl=0) then FSM returns to FULL.
REQ-026 flush has top priority: next edge clears valid, FSM->EMPTY, redirect_valid=0, no accept that cycle.
REQ-027 Simultaneous transfer and accept: register reloads, FSM stays FULL (or SHADOW rule applies).
REQ-028 Arithmetic modulo 2^XLEN; SXT extends C to XLEN.

Reset
REQ-029 On rst: valid=0, FSM=EMPTY, out_valid=0, redirect_valid=0, out_ir=`INST_NOP, all other outputs 0.
REQ-030 Reset mid-stall or mid-shadow discards held instruction; in_ready=1 first cycle after release.

Configuration
REQ-031 DECODE_STALL_CNT_EN defined: output stall_cnt[31:0] counts cycles in STALL, saturates at 32'hFFFF_FFFF, cleared by rst and flush.
REQ-032 DECODE_STALL_CNT_EN undefined: stall_cnt port and counter absent; all other behaviour identical.

Structure
REQ-033 Package decode_pkg holds opcode constants, dec_ctl_t, FSM state enum, INST_NOP value.
REQ-034 Sub-module decode_hazard: per-source channel match, bypass select and hazard flag, parametrised by XLEN and NUM_BYP.

Verification
REQ-035 ADD R1,R2,R3, no channel matches, rf_rd1=5, rf_rd2=7 -> out_a=5, out_b=7, one-cycle latency.
REQ-036 Ra=R4, channel 0 addr 4 is_load=1 for 2 cycles -> 2 stall cycles, in_ready=0, then out_a=byp_data[0].
REQ-037 Channels 0 and 2 both addr 6 non-load, data 0x11/0x22 -> operand 0x11.
REQ-038 BEQ pc=0x100, C=0xFFFF, A=0 -> redirect_valid=1, redirect_pc=0xFC; next accepted instr emitted as NOP.
REQ-039 flush asserted during STALL -> out_valid=0 next cycle, FSM EMPTY, stall_cnt=0 when enabled.
REQ-040 Force stall_cnt to 0xFFFFFFFF, hold STALL -> value stays 0xFFFFFFFF.
